// File: rtl/hmc_phy_init_pkg.sv
// rtl/hmc_phy_init_pkg.sv - shared state encoding and default constants for the PHY init sequencer
package hmc_phy_init_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_PHY  = 3'd1,
    ST_INIT_CONT = 3'd2,
    ST_CHECK     = 3'd3,
    ST_SLIP      = 3'd4,
    ST_SETTLE    = 3'd5,
    ST_LOCKED    = 3'd6,
    ST_FAIL      = 3'd7
  } seq_state_e;

  localparam logic [31:0] DEFAULT_TRAIN_PAT = 32'hF0C3_A55A;
  localparam int          DEFAULT_SLIP_WAIT = 8;

endpackage

// File: rtl/hmc_phy_lane_checker.sv
// rtl/hmc_phy_lane_checker.sv - combinational compare of one lane word against the training pattern
module hmc_phy_lane_checker #(
  parameter int                LANE_W = 32,
  parameter logic [LANE_W-1:0] PAT    = '0
) (
  input  logic [LANE_W-1:0] word,
  output logic              match,
  output logic              inv_match
);

  assign match     = (word == PAT);
  assign inv_match = (word == ~PAT);

endmodule

// File: rtl/hmc_phy_init_sequencer.sv
// rtl/hmc_phy_init_sequencer.sv - PHY bring-up: ready wait, PHY release, per-lane bit-slip/polarity alignment
module hmc_phy_init_sequencer
  import hmc_phy_init_pkg::*;
#(
  parameter int                              DWIDTH               = 512,
  parameter int                              NUM_LANES            = 16,
  parameter logic [DWIDTH/NUM_LANES-1:0]     TRAIN_PAT            = DEFAULT_TRAIN_PAT,
  parameter bit                              DETECT_LANE_POLARITY = 1'b1,
  parameter int                              SLIP_WAIT            = DEFAULT_SLIP_WAIT,
  parameter int                              MAX_ITER             = 2 * (DWIDTH / NUM_LANES),
  parameter int                              READY_TIMEOUT        = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_en,
  input  logic                 phy_tx_ready,
  input  logic                 phy_rx_ready,
  input  logic [DWIDTH-1:0]    phy_data_rx_phy2link,
  output logic [NUM_LANES-1:0] phy_bit_slip,
  output logic [NUM_LANES-1:0] phy_lane_polarity,
  output logic                 phy_init_cont_set,
  output logic [NUM_LANES-1:0] lanes_aligned,
  output logic                 link_locked,
  output logic                 init_fail,
  output logic [2:0]           seq_state
);

  localparam int LANE_W  = DWIDTH / NUM_LANES;
  localparam int ITER_W  = $clog2(MAX_ITER + 1);
  localparam int TIMER_W = $clog2(READY_TIMEOUT + 1);
  localparam int WAIT_W  = $clog2(SLIP_WAIT + 1);

  localparam logic [ITER_W-1:0]  ITER_MAX  = ITER_W'(MAX_ITER);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(READY_TIMEOUT);
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

  seq_state_e           state, state_nxt;
  logic [ITER_W-1:0]    iter, iter_nxt;
  logic [TIMER_W-1:0]   timer, timer_nxt;
  logic [WAIT_W-1:0]    wait_cnt, wait_nxt;
  logic [NUM_LANES-1:0] aligned, aligned_nxt;
  logic [NUM_LANES-1:0] polarity, polarity_nxt;
  logic [NUM_LANES-1:0] match, inv_match;
  logic [NUM_LANES-1:0] match_new, pol_new, slip_mask;
  logic                 link_state;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    hmc_phy_lane_checker #(
      .LANE_W (LANE_W),
      .PAT    (TRAIN_PAT)
    ) u_checker (
      .word      (phy_data_rx_phy2link[i*LANE_W +: LANE_W]),
      .match     (match[i]),
      .inv_match (inv_match[i])
    );
  end

  // A lane that already had its polarity flipped and still reads inverted is treated as misaligned.
  always_comb begin
    match_new = ~aligned & match;
    pol_new   = DETECT_LANE_POLARITY ? (~aligned & ~match & inv_match & ~polarity) : '0;
    slip_mask = ~aligned & ~match & ~pol_new;
  end

  assign link_state = (state == ST_INIT_CONT) || (state == ST_CHECK) || (state == ST_SLIP) ||
                      (state == ST_SETTLE) || (state == ST_LOCKED);

  always_comb begin
    state_nxt    = state;
    iter_nxt     = iter;
    timer_nxt    = '0;
    wait_nxt     = '0;
    aligned_nxt  = aligned;
    polarity_nxt = polarity;

    if (!cfg_en) begin
      state_nxt = ST_IDLE;
    end else if (!phy_rx_ready && link_state) begin
      state_nxt = ST_WAIT_PHY;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_WAIT_PHY;
        ST_WAIT_PHY: begin
          timer_nxt = (timer == TIMER_MAX) ? timer : timer + TIMER_W'(1);
          if (phy_tx_ready && phy_rx_ready) state_nxt = ST_INIT_CONT;
          else if (timer_nxt == TIMER_MAX)  state_nxt = ST_FAIL;
        end
        ST_INIT_CONT, ST_SETTLE: begin
          if (wait_cnt == WAIT_LAST) state_nxt = ST_CHECK;
          else                       wait_nxt  = wait_cnt + WAIT_W'(1);
        end
        ST_CHECK: begin
          aligned_nxt  = aligned | match_new;
          polarity_nxt = polarity | pol_new;
          if (&(aligned | match_new)) begin
            state_nxt = ST_LOCKED;
          end else if (iter == ITER_MAX) begin
            state_nxt = ST_FAIL;
          end else begin
            iter_nxt  = iter + ITER_W'(1);
            state_nxt = ST_SLIP;
          end
        end
        ST_SLIP:   state_nxt = ST_SETTLE;
        ST_LOCKED: state_nxt = ST_LOCKED;
        ST_FAIL:   state_nxt = ST_FAIL;
        default:   state_nxt = ST_IDLE;
      endcase
    end

    // Any return to IDLE or WAIT_PHY restarts alignment from scratch.
    if (state_nxt == ST_IDLE || state_nxt == ST_WAIT_PHY) begin
      aligned_nxt  = '0;
      polarity_nxt = '0;
      iter_nxt     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      iter              <= '0;
      timer             <= '0;
      wait_cnt          <= '0;
      aligned           <= '0;
      polarity          <= '0;
      phy_bit_slip      <= '0;
      phy_init_cont_set <= 1'b0;
      link_locked       <= 1'b0;
      init_fail         <= 1'b0;
    end else begin
      state             <= state_nxt;
      iter              <= iter_nxt;
      timer             <= timer_nxt;
      wait_cnt          <= wait_nxt;
      aligned           <= aligned_nxt;
      polarity          <= polarity_nxt;
      phy_bit_slip      <= (state_nxt == ST_SLIP) ? slip_mask : '0;
      phy_init_cont_set <= state_nxt inside {ST_INIT_CONT, ST_CHECK, ST_SLIP, ST_SETTLE, ST_LOCKED};
      link_locked       <= (state_nxt == ST_LOCKED);
      init_fail         <= (state_nxt == ST_FAIL);
    end
  end

  assign lanes_aligned     = aligned;
  assign phy_lane_polarity = polarity;
  assign seq_state         = state;

endmodule

// File: tb/tb_hmc_phy_init_sequencer.sv
// tb/tb_hmc_phy_init_sequencer.sv - self-checking bench with a rotating-lane PHY model and slip scoreboard
module tb_hmc_phy_init_sequencer;

  localparam int          DW  = 128;
  localparam int          NL  = 4;
  localparam int          LW  = 32;
  localparam int          SW  = 4;
  localparam int          RT  = 16;
  localparam int          MI  = 64;
  localparam logic [31:0] PAT = 32'hF0C3_A55A;

  localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_INIT = 3'd2, S_CHECK = 3'd3,
                         S_LOCKED = 3'd6, S_FAIL = 3'd7;

  logic          clk = 1'b0;
  logic          rst, cfg_en, phy_tx_ready, phy_rx_ready;
  logic [DW-1:0] phy_data_rx_phy2link;
  logic [NL-1:0] phy_bit_slip, phy_lane_polarity, lanes_aligned;
  logic          phy_init_cont_set, link_locked, init_fail;
  logic [2:0]    seq_state;

  hmc_phy_init_sequencer #(
    .DWIDTH        (DW),
    .NUM_LANES     (NL),
    .SLIP_WAIT     (SW),
    .READY_TIMEOUT (RT)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .cfg_en               (cfg_en),
    .phy_tx_ready         (phy_tx_ready),
    .phy_rx_ready         (phy_rx_ready),
    .phy_data_rx_phy2link (phy_data_rx_phy2link),
    .phy_bit_slip         (phy_bit_slip),
    .phy_lane_polarity    (phy_lane_polarity),
    .phy_init_cont_set    (phy_init_cont_set),
    .lanes_aligned        (lanes_aligned),
    .link_locked          (link_locked),
    .init_fail            (init_fail),
    .seq_state            (seq_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // PHY model: each slip pulse rotates the lane one bit back towards the pattern.
  int            rot_init [NL];
  int            slip_cnt [NL];
  logic [NL-1:0] lane_inv, lane_zero;
  logic          model_clear;

  function automatic logic [31:0] rotl(input logic [31:0] p, input int r);
    int k;
    k = ((r % 32) + 32) % 32;
    if (k == 0) return p;
    return (p << k) | (p >> (32 - k));
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NL; i++) begin
      if (model_clear)          slip_cnt[i] <= 0;
      else if (phy_bit_slip[i]) slip_cnt[i] <= slip_cnt[i] + 1;
    end
  end

  always_comb begin
    phy_data_rx_phy2link = '0;
    for (int i = 0; i < NL; i++) begin
      phy_data_rx_phy2link[i*LW +: LW] = lane_zero[i] ? 32'h0 :
        (rotl(PAT, rot_init[i] - slip_cnt[i]) ^ {LW{lane_inv[i] ^ phy_lane_polarity[i]}});
    end
  end

  logic [NL-1:0] obs_mask [$];
  int            obs_cyc  [$];
  always @(negedge clk) begin
    if (phy_bit_slip != '0) begin
      obs_mask.push_back(phy_bit_slip);
      obs_cyc.push_back(cyc);
    end
  end

  logic [NL-1:0] sb [$];
  int            obs_base;
  int            tests = 0;
  int            fails = 0;

  task automatic wait_state(input logic [2:0] tgt, input int max, input string name);
    int n = 0;
    while (seq_state !== tgt && n < max) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (seq_state !== tgt) begin
      fails++;
      $display("FAIL %s: seq_state=%0d, expected %0d within %0d cycles", name, seq_state, tgt, max);
    end
  endtask

  task automatic restart();
    cfg_en      = 1'b0;
    model_clear = 1'b1;
    @(negedge clk);
    model_clear = 1'b0;
    obs_base    = obs_mask.size();
    sb.delete();
    cfg_en      = 1'b1;
  endtask

  task automatic check_slips(input string name);
    int            n;
    logic [NL-1:0] exp;
    n = obs_mask.size() - obs_base;
    tests++;
    if (n != sb.size()) begin
      fails++;
      $display("FAIL %s slip count: got %0d, expected %0d", name, n, sb.size());
    end
    for (int i = 0; i < n && sb.size() > 0; i++) begin
      exp = sb.pop_front();
      tests++;
      if (obs_mask[obs_base + i] !== exp) begin
        fails++;
        $display("FAIL %s slip %0d: got %b, expected %b", name, i, obs_mask[obs_base + i], exp);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_en = 1'b1; phy_tx_ready = 1'b0; phy_rx_ready = 1'b0;
    lane_inv = '0; lane_zero = '0; model_clear = 1'b1;
    for (int i = 0; i < NL; i++) rot_init[i] = 0;
    repeat (3) @(negedge clk);
    tests++;
    if ({phy_bit_slip, phy_lane_polarity, lanes_aligned, phy_init_cont_set, link_locked, init_fail} !== '0) begin
      fails++;
      $display("FAIL reset outputs: slip=%b pol=%b al=%b ics=%b lk=%b fl=%b, expected all 0",
               phy_bit_slip, phy_lane_polarity, lanes_aligned, phy_init_cont_set, link_locked, init_fail);
    end
    tests++;
    if (seq_state !== S_IDLE) begin
      fails++;
      $display("FAIL reset state: got %0d, expected 0", seq_state);
    end
    rst = 1'b0; model_clear = 1'b0;
    obs_base = obs_mask.size();
    @(negedge clk);
    tests++;
    if (seq_state !== S_WAIT) begin
      fails++;
      $display("FAIL release state: got %0d, expected 1", seq_state);
    end
  endtask

  task automatic test_aligned();
    repeat (8) @(negedge clk);
    phy_tx_ready = 1'b1; phy_rx_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (seq_state !== S_INIT || phy_init_cont_set !== 1'b1) begin
      fails++;
      $display("FAIL init_cont entry: state=%0d ics=%b, expected 2/1", seq_state, phy_init_cont_set);
    end
    repeat (4) @(negedge clk);
    tests++;
    if (seq_state !== S_CHECK || link_locked !== 1'b0) begin
      fails++;
      $display("FAIL check timing: state=%0d lk=%b, expected 3/0", seq_state, link_locked);
    end
    @(negedge clk);
    tests++;
    if (seq_state !== S_LOCKED || link_locked !== 1'b1 || lanes_aligned !== 4'hF) begin
      fails++;
      $display("FAIL lock timing: state=%0d lk=%b al=%b, expected 6/1/1111", seq_state, link_locked, lanes_aligned);
    end
    check_slips("aligned");
  endtask

  task automatic test_bit_slip();
    rot_init[2] = 3;
    restart();
    repeat (3) sb.push_back(4'b0100);
    wait_state(S_LOCKED, 300, "slip lock");
    check_slips("bit_slip");
    for (int i = 1; i < 3 && obs_base + i < obs_mask.size(); i++) begin
      tests++;
      if (obs_cyc[obs_base + i] - obs_cyc[obs_base + i - 1] != 6) begin
        fails++;
        $display("FAIL slip spacing %0d: got %0d cycles, expected 6", i,
                 obs_cyc[obs_base + i] - obs_cyc[obs_base + i - 1]);
      end
    end
    tests++;
    if (phy_lane_polarity !== 4'b0000 || lanes_aligned !== 4'hF) begin
      fails++;
      $display("FAIL slip final: pol=%b al=%b, expected 0000/1111", phy_lane_polarity, lanes_aligned);
    end
  endtask

  task automatic test_polarity();
    rot_init[2] = 0;
    lane_inv[1] = 1'b1;
    restart();
    wait_state(S_CHECK, 50, "polarity check");
    @(negedge clk);
    tests++;
    if (phy_lane_polarity !== 4'b0010 || lanes_aligned !== 4'b1101) begin
      fails++;
      $display("FAIL polarity first check: pol=%b al=%b, expected 0010/1101", phy_lane_polarity, lanes_aligned);
    end
    wait_state(S_LOCKED, 50, "polarity lock");
    tests++;
    if (phy_lane_polarity !== 4'b0010 || lanes_aligned !== 4'hF) begin
      fails++;
      $display("FAIL polarity locked: pol=%b al=%b, expected 0010/1111", phy_lane_polarity, lanes_aligned);
    end
    check_slips("polarity");
  endtask

  task automatic test_max_iter();
    lane_inv     = '0;
    lane_zero[0] = 1'b1;
    restart();
    repeat (MI) sb.push_back(4'b0001);
    wait_state(S_FAIL, 1000, "max_iter fail");
    tests++;
    if (init_fail !== 1'b1 || phy_init_cont_set !== 1'b0 || link_locked !== 1'b0) begin
      fails++;
      $display("FAIL max_iter flags: fl=%b ics=%b lk=%b, expected 1/0/0", init_fail, phy_init_cont_set, link_locked);
    end
    check_slips("max_iter");
    cfg_en = 1'b0;
    @(negedge clk);
    tests++;
    if (seq_state !== S_IDLE ||
        {phy_bit_slip, phy_lane_polarity, lanes_aligned, phy_init_cont_set, link_locked, init_fail} !== '0) begin
      fails++;
      $display("FAIL abort clear: state=%0d al=%b pol=%b fl=%b, expected 0 and all outputs 0",
               seq_state, lanes_aligned, phy_lane_polarity, init_fail);
    end
  endtask

  task automatic test_rx_drop();
    lane_zero    = '0;
    lane_inv[3]  = 1'b1;
    restart();
    wait_state(S_LOCKED, 100, "rx_drop lock");
    tests++;
    if (phy_lane_polarity !== 4'b1000) begin
      fails++;
      $display("FAIL rx_drop pre polarity: got %b, expected 1000", phy_lane_polarity);
    end
    phy_rx_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (seq_state !== S_WAIT || lanes_aligned !== '0 || phy_lane_polarity !== '0 ||
        phy_init_cont_set !== 1'b0 || link_locked !== 1'b0) begin
      fails++;
      $display("FAIL rx_drop clear: state=%0d al=%b pol=%b ics=%b lk=%b, expected 1/0/0/0/0",
               seq_state, lanes_aligned, phy_lane_polarity, phy_init_cont_set, link_locked);
    end
    repeat (RT - 1) @(negedge clk);
    tests++;
    if (seq_state !== S_WAIT) begin
      fails++;
      $display("FAIL timeout early: state=%0d, expected 1", seq_state);
    end
    @(negedge clk);
    tests++;
    if (seq_state !== S_FAIL || init_fail !== 1'b1) begin
      fails++;
      $display("FAIL timeout: state=%0d fl=%b, expected 7/1", seq_state, init_fail);
    end
    check_slips("rx_drop");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_aligned();
    test_bit_slip();
    test_polarity();
    test_max_iter();
    test_rx_drop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
